ex_sorter_serializer: RTL and testbench

- Consumer-side companion to the four-element sorting unit.
- Captures each sorted 4-tuple presented on a val-only parallel interface (in_val, in0..in3) into a two-entry quad buffer.
- Streams the elements out one per cycle, lowest index first, on a latency-insensitive val/rdy interface.
- Flags dropped quads, since the upstream sorter cannot be stalled.

---
 rtl/ex_sorter_serializer.sv | 157 +++++++++++++++
 tb/tb_ex_sorter_serializer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ex_sorter_serializer.sv
// ex_sorter_serializer
// Captures sorted 4-tuples from a non-stallable val-only parallel interface
// into a two-entry quad buffer. It then streams the elements out one per cycle,
// lowest index first, on a val/rdy interface.
// A quad that arrives while both entries are occupied is dropped, and the
// sticky overflow flag is raised.
// Optional build macro: EX_SORTER_SERIALIZER_ORDER_CHECK_EN
//   When defined, each accepted quad is checked for in0<=in1<=in2<=in3
//   (unsigned). A violation raises the sticky order_err flag.
//   When undefined, no comparators are built and order_err is tied low.

module ex_sorter_serializer #(
    parameter int p_nbits = 1
) (
    input  logic               clk,
    input  logic               reset,      // synchronous, active-low
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic [p_nbits-1:0] in2,
    input  logic [p_nbits-1:0] in3,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg,
    output logic               out_last,
    output logic               overflow,
    output logic               order_err
);

    typedef logic [3:0][p_nbits-1:0] quad_t;

    // Quad storage and control state
    quad_t [1:0] qbuf_q, qbuf_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q,  count_d;
    logic [1:0]  idx_q,    idx_d;
    logic        overflow_q, overflow_d;

    logic  accept;
    logic  pop;
    logic  retire;
    logic  drop;
    quad_t in_quad;

    assign in_quad = {in3, in2, in1, in0};

    // Output decode comes from registered state only. It has no combinational
    // path from out_rdy.
    assign in_rdy   = (count_q != 2'd2);
    assign out_val  = (count_q != 2'd0);
    assign out_msg  = qbuf_q[rd_ptr_q][idx_q];
    assign out_last = out_val && (idx_q == 2'd3);
    assign overflow = overflow_q;

    assign accept = in_val && in_rdy;
    assign drop   = in_val && !in_rdy;
    assign pop    = out_val && out_rdy;
    assign retire = pop && (idx_q == 2'd3);

    // Next-state: buffer write, pointer/index advance, occupancy, overflow
    always_comb begin
        // NOTE: every signal gets a default first so that no path leaves it
        // unassigned. An unassigned path would infer a latch.
        qbuf_d     = qbuf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;

        if (accept) begin
            qbuf_d[wr_ptr_q] = in_quad;
            wr_ptr_d         = ~wr_ptr_q;
        end

        if (pop) begin
            idx_d = idx_q + 2'd1;       // wraps 3 -> 0 naturally
            if (retire) begin
                rd_ptr_d = ~rd_ptr_q;
            end
        end

        // A full buffer deasserts in_rdy. So accept and retire in the same cycle
        // only happen at count==1, and the count stays put.
        if (accept && !retire) begin
            count_d = count_q + 2'd1;
        end else if (retire && !accept) begin
            count_d = count_q - 2'd1;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. All flops then
        // see pre-edge values, whatever the order of the statements.
        if (!reset) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            idx_q      <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Quad storage register
    always_ff @(posedge clk) begin
        // NOTE: the data array is not reset. count==0 already masks stale
        // contents, and leaving reset off keeps the storage a plain memory.
        qbuf_q <= qbuf_d;
    end

`ifdef EX_SORTER_SERIALIZER_ORDER_CHECK_EN
    logic order_ok;
    logic order_err_q, order_err_d;

    // Unsigned monotonic check across the incoming quad
    always_comb begin
        order_ok    = (in0 <= in1) && (in1 <= in2) && (in2 <= in3);
        order_err_d = order_err_q;
        if (accept && !order_ok) begin
            order_err_d = 1'b1;
        end
    end

    // Sticky ordering-violation flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            order_err_q <= 1'b0;
        end else begin
            order_err_q <= order_err_d;
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

`ifndef SYNTHESIS
    // Handshake controls must be known whenever the block is out of reset
    a_ctrl_known : assert property (@(posedge clk) disable iff (!reset)
        !$isunknown({in_val, out_rdy, out_val, in_rdy}));
`endif

endmodule

// File: tb/tb_ex_sorter_serializer.sv
// Directed bench for ex_sorter_serializer, p_nbits=8.
// Stimulus pushes the expected element stream into a scoreboard queue. A
// separate monitor pops and compares on every output handshake.
// Run with or without EX_SORTER_SERIALIZER_ORDER_CHECK_EN.

module tb_ex_sorter_serializer;

    localparam int W = 8;

`ifdef EX_SORTER_SERIALIZER_ORDER_CHECK_EN
    localparam logic EXP_ORDER_ERR = 1'b1;
`else
    localparam logic EXP_ORDER_ERR = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] msg;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_val = 1'b0;
    logic         in_rdy;
    logic [W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic         out_val;
    logic         out_rdy = 1'b0;
    logic [W-1:0] out_msg;
    logic         out_last;
    logic         overflow;
    logic         order_err;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    ex_sorter_serializer #(.p_nbits(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_val    (in_val),
        .in_rdy    (in_rdy),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_msg   (out_msg),
        .out_last  (out_last),
        .overflow  (overflow),
        .order_err (order_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one quad for a single cycle. The first n_exp elements go into
    // the scoreboard as the elements expected to come out.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d,
                        input int n_exp);
        logic [W-1:0] e [4];
        e[0] = a; e[1] = b; e[2] = c; e[3] = d;
        for (int i = 0; i < n_exp; i++) begin
            sb.push_back('{msg: e[i], last: (i == 3)});
        end
        in0 = a; in1 = b; in2 = c; in3 = d;
        in_val = 1'b1;
        step();
        in_val = 1'b0;
    endtask

    // Monitor: compare every output handshake against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && out_val && out_rdy) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: actual=%0h required=none", out_msg);
                end else begin
                    e = sb.pop_front();
                    check("out_msg", 32'(out_msg), 32'(e.msg));
                    check("out_last", 32'(out_last), 32'(e.last));
                end
            end
        end
    end

    initial begin
        // Reset state
        step();
        step();
        check("rst_out_val", 32'(out_val), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_in_rdy", 32'(in_rdy), 1);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_order_err", 32'(order_err), 0);
        reset = 1'b1;
        step();

        // Single quad, one-cycle latency, out_last only on element 3
        out_rdy = 1'b1;
        send(8'h03, 8'h05, 8'h0a, 8'hff, 4);
        check("lat_out_val", 32'(out_val), 1);
        check("lat_out_msg", 32'(out_msg), 32'h03);
        repeat (4) step();
        check("single_idle_val", 32'(out_val), 0);
        check("single_idle_rdy", 32'(in_rdy), 1);
        check("single_order_err", 32'(order_err), 0);
        check("single_sb_empty", 32'(sb.size()), 0);

        // Backpressure: element 0 holds for 3 cycles, then the rest streams
        out_rdy = 1'b0;
        send(8'h01, 8'h02, 8'h03, 8'h04, 4);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_val", 32'(out_val), 1);
            check("bp_hold_msg", 32'(out_msg), 32'h01);
            check("bp_hold_last", 32'(out_last), 0);
            step();
        end
        out_rdy = 1'b1;
        repeat (4) step();
        check("bp_idle_val", 32'(out_val), 0);
        check("bp_sb_empty", 32'(sb.size()), 0);

        // Fill and overflow: the third quad is dropped
        out_rdy = 1'b0;
        send(8'h11, 8'h12, 8'h13, 8'h14, 4);
        check("fill1_in_rdy", 32'(in_rdy), 1);
        send(8'h21, 8'h22, 8'h23, 8'h24, 4);
        check("fill2_in_rdy", 32'(in_rdy), 0);
        check("fill2_overflow", 32'(overflow), 0);
        send(8'h31, 8'h32, 8'h33, 8'h34, 0);
        check("drop_overflow", 32'(overflow), 1);
        check("drop_in_rdy", 32'(in_rdy), 0);
        out_rdy = 1'b1;
        repeat (8) step();
        check("fill_idle_val", 32'(out_val), 0);
        check("fill_sb_empty", 32'(sb.size()), 0);
        check("fill_overflow_sticky", 32'(overflow), 1);

        // Accept in the same cycle as the retire: no bubble
        send(8'h41, 8'h42, 8'h43, 8'h44, 4);
        repeat (3) step();
        check("retire_last", 32'(out_last), 1);
        send(8'h51, 8'h52, 8'h53, 8'h54, 4);
        check("nobubble_val", 32'(out_val), 1);
        check("nobubble_msg", 32'(out_msg), 32'h51);
        check("nobubble_in_rdy", 32'(in_rdy), 1);
        repeat (4) step();
        check("retire_idle_val", 32'(out_val), 0);

        // Reset mid-stream after two elements have popped
        send(8'h61, 8'h62, 8'h63, 8'h64, 2);
        repeat (2) step();
        reset = 1'b0;
        step();
        check("mid_rst_out_val", 32'(out_val), 0);
        check("mid_rst_in_rdy", 32'(in_rdy), 1);
        check("mid_rst_overflow", 32'(overflow), 0);
        check("mid_rst_sb_empty", 32'(sb.size()), 0);
        reset = 1'b1;
        send(8'h10, 8'h20, 8'h30, 8'h40, 4);
        check("post_rst_msg", 32'(out_msg), 32'h10);
        repeat (4) step();
        check("post_rst_idle", 32'(out_val), 0);

        // Out-of-order quad: streamed unchanged, order_err according to build
        send(8'h09, 8'h02, 8'h05, 8'h07, 4);
        check("order_err", 32'(order_err), 32'(EXP_ORDER_ERR));
        check("order_first_msg", 32'(out_msg), 32'h09);
        repeat (4) step();
        check("order_err_sticky", 32'(order_err), 32'(EXP_ORDER_ERR));
        check("order_idle_val", 32'(out_val), 0);

        repeat (2) step();
        check("final_sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
